// File: rtl/sample_serializer_if.sv
// Bundle of the sample write strobe, the 3-wire serial link and the status flags
// of the sample serializer. The serializer takes the slave side.
interface sample_serializer_if #(
    parameter int N = 20
);
    logic signed [N-1:0] in_sample;
    logic                in_valid;
    logic                sclk;
    logic                fs;
    logic                sdata;
    logic                busy;
    logic                empty;
    logic                overflow;

    modport master (
        output in_sample, in_valid,
        input  sclk, fs, sdata, busy, empty, overflow
    );

    modport slave (
        input  in_sample, in_valid,
        output sclk, fs, sdata, busy, empty, overflow
    );
endinterface

// File: rtl/sample_serializer.sv
// Parallel-to-serial transmitter: buffers signed samples in a small FIFO and shifts
// each one out MSB-first on sclk/fs/sdata, followed by a one-bit-period gap.
module sample_serializer #(
    parameter int N       = 20,
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 4
) (
    input  logic                ck,
    input  logic                rst,
    sample_serializer_if.slave  bus
);
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(N);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [BIT_W-1:0]   bit_cnt;
    logic [N-1:0]       shreg;

    logic [N-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               sclk_q;
    logic               fs_q;
    logic               sdata_q;
    logic               busy_q;
    logic               overflow_q;

    logic               fifo_empty;
    logic               period_end;
    logic               pop;
    logic               push;
    logic [N-1:0]       head;

    assign fifo_empty = (count == '0);
    assign period_end = (div == DIV_LAST);
    assign head       = mem[rd_ptr];

    // A full FIFO still accepts a write when the FSM frees a slot on the same edge.
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == GAP) && period_end));
    assign push = bus.in_valid && ((count != CNT_FULL) || pop);

    always_ff @(posedge ck) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_sample;
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (bus.in_valid && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Outputs are registered alongside the state so the MSB and fs appear on the
    // cycle right after the pop, with sclk low for the first half of every bit.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk_q  <= 1'b0;
            fs_q    <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclk_q  <= 1'b0;
                    fs_q    <= 1'b0;
                    sdata_q <= 1'b0;
                    busy_q  <= 1'b0;
                    div     <= '0;
                    bit_cnt <= '0;
                    if (pop) begin
                        state   <= SHIFT;
                        shreg   <= head;
                        sdata_q <= head[N-1];
                        fs_q    <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (period_end) begin
                        div    <= '0;
                        sclk_q <= 1'b0;
                        fs_q   <= 1'b0;
                        shreg  <= {shreg[N-2:0], 1'b0};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            sdata_q <= 1'b0;
                            state   <= GAP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            sdata_q <= shreg[N-2];
                        end
                    end else begin
                        div    <= div + DIV_W'(1);
                        sclk_q <= (div >= DIV_RISE);
                    end
                end

                GAP: begin
                    if (period_end) begin
                        div     <= '0;
                        sclk_q  <= 1'b0;
                        bit_cnt <= '0;
                        if (pop) begin
                            state   <= SHIFT;
                            shreg   <= head;
                            sdata_q <= head[N-1];
                            fs_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            sdata_q <= 1'b0;
                            fs_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        div    <= div + DIV_W'(1);
                        sclk_q <= (div >= DIV_RISE);
                    end
                end

                default: begin
                    state   <= IDLE;
                    div     <= '0;
                    bit_cnt <= '0;
                    sclk_q  <= 1'b0;
                    fs_q    <= 1'b0;
                    sdata_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sclk     = sclk_q;
    assign bus.fs       = fs_q;
    assign bus.sdata    = sdata_q;
    assign bus.busy     = busy_q;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: a serial receiver model rebuilds each word on sclk
// rising edges and compares it against a queue of words expected on the link.
module tb_sample_serializer;
    localparam int N       = 20;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int BIT_CYC = 2 * CLK_DIV;
    localparam int FRAME   = (N + 1) * BIT_CYC;

    logic ck  = 1'b0;
    logic rst = 1'b1;

    sample_serializer_if #(.N(N)) bus();

    sample_serializer #(
        .N       (N),
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    always #5 ck = ~ck;

    int cyc = 0;
    always @(posedge ck) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    logic [N-1:0] sb[$];

    typedef struct {
        logic [N-1:0] sample;
        logic [N-1:0] bits;
    } vec_t;
    vec_t vecs[5];

    task automatic checkOutput(input string name, input int actual, input int required);
        total++;
        if (actual == required) passed++;
        else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    endtask

    task automatic noteFail(input string name, input int actual, input int required);
        total++;
        $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    endtask

    // Receiver model: fs at an sclk rise marks the MSB; N bits make a word.
    logic         prev_sclk  = 1'b0;
    logic         mon_active = 1'b0;
    int           mon_cnt    = 0;
    logic [N-1:0] mon_word   = '0;
    logic [N-1:0] exp_w;

    always @(negedge ck) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
            prev_sclk  = 1'b0;
        end else begin
            if (bus.sclk && !prev_sclk) begin
                if (bus.fs) begin
                    if (mon_active) noteFail("fs_mid_word", mon_cnt, N);
                    mon_active = 1'b1;
                    mon_cnt    = 1;
                    mon_word   = {{(N-1){1'b0}}, bus.sdata};
                end else if (mon_active) begin
                    mon_word = {mon_word[N-2:0], bus.sdata};
                    mon_cnt++;
                end else begin
                    checkOutput("gap_sdata", 32'(bus.sdata), 0);
                end
                if (mon_active && mon_cnt == N) begin
                    mon_active = 1'b0;
                    if (sb.size() == 0) begin
                        noteFail("unexpected_word", 32'(mon_word), 0);
                    end else begin
                        exp_w = sb.pop_front();
                        checkOutput("serial_word", 32'(mon_word), 32'(exp_w));
                    end
                end
            end
            prev_sclk = bus.sclk;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] s, input logic [N-1:0] expw, input bit accept);
        bus.in_sample = s;
        bus.in_valid  = 1'b1;
        if (accept) sb.push_back(expw);
        @(posedge ck);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        bit done = 1'b0;
        int spent = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (!bus.busy && bus.empty) done = 1'b1;
            else begin
                waitCycles(1);
                spent++;
            end
        end
        if (!done) noteFail(name, spent, budget);
    endtask

    // Asserts rst between clock edges and checks the outputs drop at once.
    task automatic doReset(input int hold);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_sclk", 32'(bus.sclk), 0);
        checkOutput("rst_fs", 32'(bus.fs), 0);
        checkOutput("rst_sdata", 32'(bus.sdata), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_empty", 32'(bus.empty), 1);
        checkOutput("rst_overflow", 32'(bus.overflow), 0);
        sb.delete();
        for (int i = 0; i < hold; i++) begin
            @(posedge ck);
            #1;
            bus.in_sample = N'($urandom);
            bus.in_valid  = 1'($urandom_range(0, 1));
        end
        @(posedge ck);
        #1;
        checkOutput("rst_hold_busy", 32'(bus.busy), 0);
        checkOutput("rst_hold_empty", 32'(bus.empty), 1);
        checkOutput("rst_hold_overflow", 32'(bus.overflow), 0);
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        rst = 1'b0;
        waitCycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int busy_len, fs_len, sclk_hi, t0, t1;
        bit found, dropped, prev_fs, seen;
        logic [N-1:0] s;

        vecs[0] = '{20'h5A5A5, 20'b0101_1010_0101_1010_0101};
        vecs[1] = '{20'hFFFFF, 20'b1111_1111_1111_1111_1111};
        vecs[2] = '{20'h80000, 20'b1000_0000_0000_0000_0000};
        vecs[3] = '{20'h00001, 20'b0000_0000_0000_0000_0001};
        vecs[4] = '{20'h3C0F1, 20'b0011_1100_0000_1111_0001};

        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        repeat (2) @(posedge ck);
        #1;
        doReset(3);

        // Single word: latency, fs width, sclk duty and total busy time.
        applyStimulus(vecs[0].sample, vecs[0].bits, 1'b1);
        checkOutput("lat_t1_busy", 32'(bus.busy), 0);
        checkOutput("lat_t1_empty", 32'(bus.empty), 0);
        waitCycles(1);
        checkOutput("lat_fs", 32'(bus.fs), 1);
        checkOutput("lat_sdata", 32'(bus.sdata), 0);
        checkOutput("lat_busy", 32'(bus.busy), 1);
        checkOutput("lat_sclk", 32'(bus.sclk), 0);
        checkOutput("lat_empty", 32'(bus.empty), 1);
        busy_len = 0;
        fs_len   = 0;
        sclk_hi  = 0;
        for (int i = 0; i < 400 && bus.busy; i++) begin
            busy_len++;
            if (bus.fs) fs_len++;
            if (bus.sclk) sclk_hi++;
            waitCycles(1);
        end
        checkOutput("fs_width", fs_len, BIT_CYC);
        checkOutput("busy_len", busy_len, FRAME);
        checkOutput("sclk_high_cycles", sclk_hi, (N + 1) * CLK_DIV);
        checkOutput("idle_sclk", 32'(bus.sclk), 0);
        checkOutput("idle_sdata", 32'(bus.sdata), 0);

        // Table of isolated words.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].sample, vecs[i].bits, 1'b1);
            waitIdle(FRAME + 20, "table_idle_timeout");
        end

        // -1 then most-negative, back to back with no IDLE between frames.
        applyStimulus(vecs[1].sample, vecs[1].bits, 1'b1);
        applyStimulus(vecs[2].sample, vecs[2].bits, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.fs) found = 1'b1;
            else waitCycles(1);
        end
        if (!found) noteFail("b2b_first_fs", 0, 1);
        t0      = cyc;
        dropped = 1'b0;
        prev_fs = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            waitCycles(1);
            if (!bus.busy) dropped = 1'b1;
            if (bus.fs && !prev_fs) found = 1'b1;
            prev_fs = bus.fs;
        end
        t1 = cyc;
        checkOutput("b2b_period", t1 - t0, FRAME);
        checkOutput("b2b_busy_drop", 32'(dropped), 0);
        checkOutput("b2b_msb", 32'(bus.sdata), 1);
        waitIdle(2 * FRAME, "b2b_idle_timeout");

        // Overflow burst: six strobes while idle, the sixth is dropped.
        checkOutput("ovf_before", 32'(bus.overflow), 0);
        for (int i = 0; i < 6; i++) begin
            s = N'(32'h12345 + i * 32'h1F0F3);
            applyStimulus(s, s, i < 5);
            checkOutput("ovf_step", 32'(bus.overflow), (i == 5) ? 1 : 0);
        end
        waitIdle(6 * FRAME, "ovf_idle_timeout");
        checkOutput("ovf_sticky", 32'(bus.overflow), 1);
        doReset(4);

        // Full FIFO with a write on the exact GAP-end pop edge.
        for (int i = 0; i < 5; i++) begin
            s = N'(32'hA0F00 + i * 32'h0333);
            applyStimulus(s, s, 1'b1);
        end
        checkOutput("full_ovf0", 32'(bus.overflow), 0);
        waitCycles(FRAME - 4);
        s = N'(32'h7C3E1);
        applyStimulus(s, s, 1'b1);
        checkOutput("fullpop_overflow", 32'(bus.overflow), 0);
        checkOutput("fullpop_empty", 32'(bus.empty), 0);
        s = N'(32'h0BEEF);
        applyStimulus(s, s, 1'b0);
        checkOutput("full_after_pop_drop", 32'(bus.overflow), 1);
        waitIdle(7 * FRAME, "full_idle_timeout");
        doReset(2);

        // Reset during bit 7 with two words queued, then a fresh word.
        applyStimulus(vecs[4].sample, vecs[4].bits, 1'b1);
        applyStimulus(vecs[3].sample, vecs[3].bits, 1'b1);
        applyStimulus(vecs[0].sample, vecs[0].bits, 1'b1);
        waitCycles(58);
        checkOutput("mid_busy", 32'(bus.busy), 1);
        doReset(3);
        applyStimulus(vecs[2].sample, vecs[2].bits, 1'b1);
        waitCycles(1);
        checkOutput("post_rst_fs", 32'(bus.fs), 1);
        checkOutput("post_rst_msb", 32'(bus.sdata), 1);
        waitIdle(FRAME + 20, "post_rst_idle_timeout");
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.busy) seen = 1'b1;
            waitCycles(1);
        end
        checkOutput("no_stale", 32'(seen), 0);

        checkOutput("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sample_serializer.md
Name: sample_serializer

Overview:
Parallel-to-serial transmitter for filtered samples. Accepts one signed N-bit sample per single-cycle valid strobe, which is the filter's output_ready/out pair, and buffers it in a small FIFO. Shifts each sample out MSB-first on a 3-wire serial link (sclk, fs, sdata) toward the DAC/board side. It is the transmit end of the sample path whose receive end feeds the filter.

Parameters:
N, 20, sample width in bits (matches filter N)
CLK_DIV, 4, ck cycles per sclk half-period; must be >= 1
DEPTH, 4, FIFO depth in samples; power of 2, >= 2

Ports:
ck  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
in_sample  input  N  signed sample, valid only when in_valid=1
in_valid  input  1  single-cycle write strobe (connect to filter output_ready)
sclk  output  1  serial bit clock
fs  output  1  frame sync, high during MSB bit period of each word
sdata  output  1  serial data, MSB first, changes on sclk falling edge
busy  output  1  high while a word (or its gap) is being transmitted
empty  output  1  FIFO empty flag
overflow  output  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (async, immediate): FIFO pointers/count cleared, state IDLE, divider and bit counter cleared. sclk=0, fs=0, sdata=0, busy=0, empty=1, overflow=0. Reset mid-word aborts the word; no partial resume.
- FIFO write: on a ck edge with in_valid=1, in_sample is written if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle. Otherwise the sample is dropped and overflow is set on that edge. overflow clears only on rst.
- FIFO pop: performed only by the FSM in IDLE or GAP-end when !empty. Pop and write in the same cycle leave count unchanged.
- empty reflects registered count==0.
- Bit timing: bit period = 2*CLK_DIV ck cycles. sclk=0 for the first CLK_DIV cycles and 1 for the second CLK_DIV cycles. sdata/fs are updated only at the start of a bit period, coincident with sclk going 0. The receiver samples on sclk rising edge.
- FSM states:
  IDLE: sclk=0, sdata=0, fs=0, busy=0. If !empty: pop head into N-bit shift register, clear bit counter and divider, go SHIFT.
  SHIFT: sdata=shreg[N-1]; fs=1 only while bit counter==0. At the end of each bit period, shift left one bit and increment the bit counter. After bit N-1 completes, go GAP.
  GAP: one full bit period with sclk toggling, sdata=0, fs=0, busy=1. At its end: if !empty, pop and go SHIFT directly (next MSB starts the following cycle); else go IDLE.
- Frame period when back-to-back: (N+1)*2*CLK_DIV ck cycles (N=20, CLK_DIV=4: 168 cycles).
- Latency: with FIFO empty and IDLE, in_valid at cycle t is written at edge t. The FSM pops at edge t+1. sdata=MSB, fs=1, busy=1 are visible from cycle t+2.
- Sample is transmitted as raw two's complement bits; no rounding or saturation.
- Divider and bit counter wrap to 0 at terminal count; no other wrap cases exist.

Test Plan:
- Reset: hold rst mid-sim with random inputs -> sclk=0, fs=0, sdata=0, busy=0, empty=1, overflow=0 the same cycle rst rises.
- Single word, N=20, CLK_DIV=4: in_valid with 20'h5A5A5 -> from t+2 sdata sequence 0101_1010_0101_1010_0101, 8 cycles/bit. fs high cycles t+2..t+9 only. 160 shift cycles plus 8 gap cycles, then busy=0 and IDLE.
- Negative value: 20'hFFFFF (-1) then 20'h80000 -> first word sdata=1 for 20 bits, gap 0. Second word starts immediately after gap (no IDLE) with a 1 followed by 19 zeros.
- Overflow burst, DEPTH=4: in_valid on 6 consecutive cycles, s0..s5, serializer idle -> s0 popped at cycle 1, s1..s4 fill FIFO, s5 dropped. overflow=1 from the edge of s5's strobe and stays 1. Serial output is s0..s4 in order, each 168-cycle frame.
- Full with simultaneous pop: FIFO full, in_valid asserted exactly on the GAP-end pop cycle -> sample accepted, count stays 4, overflow stays 0, sample transmitted in order.
- Reset mid-word: assert rst during bit 7 of a word with 2 words queued -> outputs 0 immediately, queue discarded. New sample after rst release transmits from MSB with fs high.
